// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V style control FSM with memory-timeout bus error and retired-instruction counter.
// Optional macro CTRL_ILLEGAL_TRAP_EN: unknown opcodes in EXEC halt and set the sticky illegal flag.
module multicycle_control_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic [2:0]       alu_op,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             bus_error,
  output logic             illegal
);

  localparam int WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               bus_error_q, bus_error_d;

  logic [2:0] op_alu;
  logic       op_src;
  logic       op_known;
  logic       is_load, is_store, is_branch, is_jump;
  logic       waiting, timeout, retire;

  // Opcode classification shared by EXEC and MEM.
  always_comb begin
    op_alu   = 3'b000;
    op_src   = 1'b0;
    op_known = 1'b1;
    case (opcode)
      OPC_R:      op_alu = 3'b000;
      OPC_I:      begin op_alu = 3'b001; op_src = 1'b1; end
      OPC_LOAD:   begin op_alu = 3'b010; op_src = 1'b1; end
      OPC_STORE:  begin op_alu = 3'b011; op_src = 1'b1; end
      OPC_BRANCH: op_alu = 3'b100;
      OPC_LUI:    begin op_alu = 3'b101; op_src = 1'b1; end
      OPC_AUIPC:  begin op_alu = 3'b110; op_src = 1'b1; end
      OPC_JAL:    op_alu = 3'b111;
      OPC_JALR:   begin op_alu = 3'b111; op_src = 1'b1; end
      default:    op_known = 1'b0;
    endcase
  end

  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jump   = (opcode == OPC_JAL) || (opcode == OPC_JALR);

  // Strobes depend on the current state plus same-cycle mem_ready/alu_zero.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 3'b000;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      S_EXEC: begin
        alu_op  = op_alu;
        alu_src = op_src;
        if (is_branch) pc_write = alu_zero;
        if (is_jump)   pc_write = 1'b1;
      end
      S_MEM: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        mem_we  = is_store;
        alu_op  = op_alu;
        alu_src = op_src;
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_load;
      end
      default: ;
    endcase
  end

  assign waiting = mem_req && !mem_ready;
  assign timeout = waiting && (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  logic illegal_set;
`endif

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_set = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_HALT;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (!op_known) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_d     = S_HALT;
          illegal_set = 1'b1;
`else
          state_d = S_FETCH;
          retire  = 1'b1;
`endif
        end else if (is_branch) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (is_store) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout) begin
          state_d = S_HALT;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // Counter clears whenever the request completes, times out, or no request is pending.
  assign wait_d      = (waiting && !timeout) ? wait_q + WAIT_W'(1) : '0;
  assign retired_d   = retire ? retired_q + CNT_W'(1) : retired_q;
  assign bus_error_d = bus_error_q | timeout;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal_d   = illegal_q | illegal_set;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      retired_q   <= '0;
      wait_q      <= '0;
      bus_error_q <= 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      retired_q   <= retired_d;
      wait_q      <= wait_d;
      bus_error_q <= bus_error_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q   <= illegal_d;
`endif
    end
  end

  assign state     = state_q;
  assign retired   = retired_q;
  assign bus_error = bus_error_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal   = illegal_q;
`else
  assign illegal   = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (TIMEOUT_CYCLES=4, CNT_W=2).
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       alu_zero;
  logic       mem_ready;
  logic       mem_req, mem_we, i_or_d, ir_write, pc_write, reg_write, mem_to_reg, alu_src;
  logic [2:0] alu_op;
  logic [2:0] state;
  logic [1:0] retired;
  logic       bus_error;
  logic       illegal;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  multicycle_control_unit #(.TIMEOUT_CYCLES(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
    .alu_op(alu_op), .state(state), .retired(retired), .bus_error(bus_error), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // {mem_req, mem_we, i_or_d, ir_write, pc_write, reg_write, mem_to_reg, alu_src, alu_op}
  function automatic logic [10:0] sig();
    return {mem_req, mem_we, i_or_d, ir_write, pc_write, reg_write, mem_to_reg, alu_src, alu_op};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; opcode = 7'b0; alu_zero = 1'b0; mem_ready = 1'b0;
    tick(); tick();
    rst = 1'b0; settle();
    check("rst_state", state, 0);
    check("rst_retired", retired, 0);
    check("rst_bus_error", bus_error, 0);
    check("rst_illegal", illegal, 0);
    check("rst_sig", sig(), 11'b1_0_0_0_0_0_0_0_000);

    // R-type
    opcode = 7'b0110011; mem_ready = 1'b1; settle();
    check("r_fetch", sig(), 11'b1_0_0_1_1_0_0_0_000);
    tick(); mem_ready = 1'b0; settle();
    check("r_decode_state", state, 1);
    check("r_decode_sig", sig(), 11'b0);
    tick();
    check("r_exec_state", state, 2);
    check("r_exec_sig", sig(), 11'b0);
    tick();
    check("r_wb_state", state, 4);
    check("r_wb_sig", sig(), 11'b0_0_0_0_0_1_0_0_000);
    check("r_wb_retired", retired, 0);
    tick();
    check("r_done_state", state, 0);
    check("r_done_retired", retired, 1);

    // Load with 3 wait cycles in MEM
    opcode = 7'b0000011; mem_ready = 1'b1; settle();
    check("ld_fetch", sig(), 11'b1_0_0_1_1_0_0_0_000);
    tick(); mem_ready = 1'b0; settle();
    check("ld_decode", state, 1);
    tick();
    check("ld_exec_sig", sig(), 11'b0_0_0_0_0_0_0_1_010);
    for (int i = 0; i < 4; i++) begin
      tick();
      mem_ready = (i == 3); settle();
      check("ld_mem_state", state, 3);
      check("ld_mem_sig", sig(), 11'b1_0_1_0_0_0_0_1_010);
    end
    tick(); mem_ready = 1'b0; settle();
    check("ld_wb_state", state, 4);
    check("ld_wb_sig", sig(), 11'b0_0_0_0_0_1_1_0_000);
    tick();
    check("ld_done_state", state, 0);
    check("ld_done_retired", retired, 2);

    // Store, memory ready immediately
    opcode = 7'b0100011; mem_ready = 1'b1; settle();
    tick(); mem_ready = 1'b0; settle();
    tick();
    check("st_exec_sig", sig(), 11'b0_0_0_0_0_0_0_1_011);
    tick(); mem_ready = 1'b1; settle();
    check("st_mem_sig", sig(), 11'b1_1_1_0_0_0_0_1_011);
    tick(); mem_ready = 1'b0; settle();
    check("st_done_state", state, 0);
    check("st_done_retired", retired, 3);

    // Branch taken; fourth retire wraps the 2-bit counter
    opcode = 7'b1100011; alu_zero = 1'b1; mem_ready = 1'b1; settle();
    tick(); mem_ready = 1'b0; settle();
    tick();
    check("br1_exec_state", state, 2);
    check("br1_exec_sig", sig(), 11'b0_0_0_0_1_0_0_0_100);
    tick();
    check("br1_done_state", state, 0);
    check("br1_wrap_retired", retired, 0);

    // Branch not taken
    alu_zero = 1'b0; mem_ready = 1'b1; settle();
    tick(); mem_ready = 1'b0; settle();
    tick();
    check("br0_exec_sig", sig(), 11'b0_0_0_0_0_0_0_0_100);
    tick();
    check("br0_done_state", state, 0);
    check("br0_retired", retired, 1);

    // JAL
    opcode = 7'b1101111; mem_ready = 1'b1; settle();
    tick(); mem_ready = 1'b0; settle();
    tick();
    check("jal_exec_sig", sig(), 11'b0_0_0_0_1_0_0_0_111);
    tick();
    check("jal_wb_state", state, 4);
    tick();
    check("jal_retired", retired, 2);

    // Unrecognised opcode
    opcode = 7'b1111111; mem_ready = 1'b1; settle();
    tick(); mem_ready = 1'b0; settle();
    tick();
    check("ill_exec_sig", sig(), 11'b0);
    tick();
`ifdef CTRL_ILLEGAL_TRAP_EN
    check("ill_state", state, 5);
    check("ill_flag", illegal, 1);
    check("ill_retired", retired, 2);
    tick();
    check("ill_halt_sig", sig(), 11'b0);
    check("ill_halt_state", state, 5);
`else
    check("nop_state", state, 0);
    check("nop_flag", illegal, 0);
    check("nop_retired", retired, 3);
`endif
    rst = 1'b1; tick(); rst = 1'b0; settle();
    check("rst2_state", state, 0);
    check("rst2_retired", retired, 0);
    check("rst2_illegal", illegal, 0);

    // mem_ready on the timeout cycle wins over bus error
    opcode = 7'b0110011; mem_ready = 1'b0; settle();
    tick(); tick(); tick();
    mem_ready = 1'b1; settle();
    check("prio_sig", sig(), 11'b1_0_0_1_1_0_0_0_000);
    tick(); mem_ready = 1'b0; settle();
    check("prio_state", state, 1);
    check("prio_bus_error", bus_error, 0);
    tick(); tick(); tick();
    check("prio_retired", retired, 1);
    check("prio_fetch", state, 0);

    // Fetch timeout
    tick(); tick(); tick();
    check("to_pre_state", state, 0);
    check("to_pre_bus_error", bus_error, 0);
    tick();
    check("to_state", state, 5);
    check("to_bus_error", bus_error, 1);
    check("to_sig", sig(), 11'b0);
    mem_ready = 1'b1; tick();
    check("to_halt_state", state, 5);
    check("to_halt_retired", retired, 1);
    mem_ready = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0; settle();
    check("rst3_state", state, 0);
    check("rst3_bus_error", bus_error, 0);
    check("rst3_retired", retired, 0);
    check("rst3_sig", sig(), 11'b1_0_0_0_0_0_0_0_000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
